// File: rtl/bsg_tx_sequencer_if.sv
// bsg_tx_sequencer_if: host register-access port of the BSG transmit sequencer.
// The host raises valid with addr/wr_en/Data_in and holds them until ready;
// ready is a one-cycle strobe and Data_out carries read data from that cycle on.
interface bsg_tx_sequencer_if;
    logic       valid;
    logic       ready;
    logic [7:0] addr;
    logic [7:0] Data_in;
    logic [7:0] Data_out;
    logic       wr_en;

    modport master (
        output valid,
        output addr,
        output Data_in,
        output wr_en,
        input  ready,
        input  Data_out
    );

    modport slave (
        input  valid,
        input  addr,
        input  Data_in,
        input  wr_en,
        output ready,
        output Data_out
    );
endinterface

// File: rtl/bsg_tx_sequencer.sv
// bsg_tx_sequencer: owns the BSG register file (CONTROL, DATA_0, DATA_1, FILL)
// and feeds DATA_0/DATA_1 alternately to the modulator, raising the refill
// interrupt whenever the modulator finishes a byte and the other buffer is empty.
// Optional feature: define BSG_TX_TIMEOUT_EN to abort a byte whose byte_done
// never arrives within TIMEOUT_CYCLES cycles of SEND (sets TOERR and INTFLAG).
module bsg_tx_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              SYS_CLK,
    input  logic              RST_N,
    bsg_tx_sequencer_if.slave host,
    input  logic              byte_done,
    output logic              tx_load,
    output logic [7:0]        tx_data,
    output logic              data_flag,
    output logic              BSG_INT
);

    localparam logic [7:0] ADDR_CONTROL = 8'h00;
    localparam logic [7:0] ADDR_DATA0   = 8'h01;
    localparam logic [7:0] ADDR_DATA1   = 8'h02;
    localparam logic [7:0] ADDR_FILL    = 8'h03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t     state_q;
    logic       ready_q;
    logic [7:0] data_out_q;
    logic [7:0] data0_q;
    logic [7:0] data1_q;
    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       sel_q;
    logic       txen_q;
    logic       intmsk_q;
    logic       intflag_q;
    logic       tx_load_q;
    logic [7:0] tx_data_q;
    logic       toerr_rd;
    logic       host_acc;
    logic       host_wr;
    logic       nsel;
    logic [7:0] data_sel;
    logic [7:0] data_nsel;
    logic [7:0] rd_data_d;

`ifdef BSG_TX_TIMEOUT_EN
    logic        toerr_q;
    logic [15:0] cnt_q;
    assign toerr_rd = toerr_q;
`else
    logic unused_timeout_cfg;
    assign toerr_rd           = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // An access happens on the edge where valid is high and the previous cycle
    // did not just complete one, so ready can never be high twice in a row.
    assign host_acc  = host.valid & ~ready_q;
    assign host_wr   = host_acc & host.wr_en;
    assign nsel      = ~sel_q;
    assign data_sel  = sel_q ? data1_q : data0_q;
    assign data_nsel = sel_q ? data0_q : data1_q;

    assign host.ready    = ready_q;
    assign host.Data_out = data_out_q;
    assign tx_load       = tx_load_q;
    assign tx_data       = tx_data_q;
    assign data_flag     = sel_q;
    assign BSG_INT       = intflag_q & intmsk_q;

    // Read-data mux and buffer-full next state; a host write to a buffer wins
    // over the clear at the end of that buffer's LOAD cycle.
    always_comb begin
        rd_data_d = 8'h00;
        case (host.addr)
            ADDR_CONTROL: rd_data_d = {3'b000, toerr_rd, (state_q != IDLE),
                                       intflag_q, intmsk_q, txen_q};
            ADDR_DATA0:   rd_data_d = data0_q;
            ADDR_DATA1:   rd_data_d = data1_q;
            ADDR_FILL:    rd_data_d = {6'b000000, full_q};
            default:      rd_data_d = 8'h00;
        endcase

        full_d = full_q;
        if (state_q == LOAD) begin
            full_d[sel_q] = 1'b0;
        end
        if (host_wr && (host.addr == ADDR_DATA0)) begin
            full_d[0] = 1'b1;
        end
        if (host_wr && (host.addr == ADDR_DATA1)) begin
            full_d[1] = 1'b1;
        end
    end

    // Register file, host handshake and the IDLE/LOAD/SEND sequencer; hardware
    // updates come after host writes so a hardware set beats a same-cycle w1c.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            data_out_q <= 8'h00;
            data0_q    <= 8'h00;
            data1_q    <= 8'h00;
            full_q     <= 2'b00;
            sel_q      <= 1'b0;
            txen_q     <= 1'b0;
            intmsk_q   <= 1'b0;
            intflag_q  <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef BSG_TX_TIMEOUT_EN
            toerr_q    <= 1'b0;
            cnt_q      <= 16'd0;
`endif
        end else begin
            ready_q   <= host_acc;
            full_q    <= full_d;
            tx_load_q <= 1'b0;
            if (host_acc) begin
                data_out_q <= rd_data_d;
            end

            if (host_wr && (host.addr == ADDR_CONTROL)) begin
                txen_q   <= host.Data_in[0];
                intmsk_q <= host.Data_in[1];
                if (host.Data_in[2]) begin
                    intflag_q <= 1'b0;
                end
`ifdef BSG_TX_TIMEOUT_EN
                if (host.Data_in[4]) begin
                    toerr_q <= 1'b0;
                end
`endif
            end
            if (host_wr && (host.addr == ADDR_DATA0)) begin
                data0_q <= host.Data_in;
            end
            if (host_wr && (host.addr == ADDR_DATA1)) begin
                data1_q <= host.Data_in;
            end

            case (state_q)
                IDLE: begin
                    if (txen_q && full_q[sel_q]) begin
                        state_q   <= LOAD;
                        tx_load_q <= 1'b1;
                        tx_data_q <= data_sel;
                    end
                end
                LOAD: begin
                    state_q <= SEND;
`ifdef BSG_TX_TIMEOUT_EN
                    cnt_q   <= 16'd0;
`endif
                end
                SEND: begin
                    if (byte_done) begin
                        sel_q <= nsel;
                        if (!full_q[nsel]) begin
                            intflag_q <= 1'b1;
                        end
                        if (txen_q && full_q[nsel]) begin
                            state_q   <= LOAD;
                            tx_load_q <= 1'b1;
                            tx_data_q <= data_nsel;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
`ifdef BSG_TX_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        toerr_q   <= 1'b1;
                        intflag_q <= 1'b1;
                        txen_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
